// File: rtl/hdmi_capture.sv
// hdmi_capture: checks DE/HS/VS frame geometry and decimates a centred window into a framebuffer write stream.
// Build option CAPTURE_LOCK_GATE_EN: when defined, writes are suppressed while locked is low.
//
// state | meaning
// IDLE  | waiting for the first VS after reset; DE and data ignored
// FRAME | counting lines/pixels, capturing the window, checking geometry
module hdmi_capture #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 144,
    parameter int XDIV        = 3,
    parameter int YDIV        = 3,
    parameter int XSTART      = 80,
    parameter int YSTART      = 24,
    parameter int HSIZE       = 640,
    parameter int VSIZE       = 480,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock25mhz,
    input  logic        resetn,
    input  logic [23:0] HDMI_RX_D,
    input  logic        HDMI_RX_DE,
    input  logic        HDMI_RX_HS,
    input  logic        HDMI_RX_VS,
    output logic        we,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        locked
);

    localparam logic        SYNC_ACT = (SYNC_POL != 0);
    localparam logic [11:0] X_LO     = 12'(XSTART);
    localparam logic [11:0] X_HI     = 12'(XSTART + XDIV * WIDTH);
    localparam logic [11:0] Y_LO     = 12'(YSTART);
    localparam logic [11:0] Y_HI     = 12'(YSTART + YDIV * HEIGHT);
    localparam logic [11:0] H_REQ    = 12'(HSIZE);
    localparam logic [11:0] V_REQ    = 12'(VSIZE);
    localparam logic [11:0] XC_LAST  = 12'(XDIV - 1);
    localparam logic [11:0] YC_LAST  = 12'(YDIV - 1);
    localparam logic [11:0] COL_LAST = 12'(WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(HEIGHT - 1);
    localparam logic [11:0] SAT      = 12'hfff;
    localparam int          GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] G_MAX  = GW'(LOCK_FRAMES);
    localparam logic [GW-1:0] G_ONE  = GW'(1);

    typedef enum logic {IDLE, FRAME} state_t;
    state_t state_q, state_d;

    logic [23:0] d0;
    logic        de0, hs0, vs0, de1, hs1, vs1;
    logic        vs_start, hs_start, line_end, active, in_win, fire, frame_end;
    logic        frame_ok_d, locked_d, locked_nxt, we_d;
    logic [11:0] hpix, vline, xcnt, ycnt, col, row;
    logic [11:0] hpix_cur, vline_cur, xcnt_cur, ycnt_cur, col_cur, row_cur;
    logic [11:0] hpix_d, vline_d, xcnt_d, ycnt_d, col_d, row_d;
    logic        line_err, line_err_d;
    logic [GW-1:0] good_cnt, good_d;

    assign vs_start = (vs0 == SYNC_ACT) && (vs1 != SYNC_ACT);
    assign hs_start = (hs0 == SYNC_ACT) && (hs1 != SYNC_ACT);

    always_comb begin : fsm_next
        state_d   = state_q;
        frame_end = 1'b0;
        case (state_q)
            IDLE:    if (vs_start) state_d = FRAME;
            FRAME:   frame_end = vs_start;
            default: state_d = IDLE;
        endcase
    end

    // A vs_start sample belongs to the new frame, so it sees all per-frame counters as zero.
    assign active    = (state_q == FRAME) || vs_start;
    assign line_end  = (state_q == FRAME) && !vs_start && de1 && !de0;
    assign hpix_cur  = vs_start ? 12'd0 : hpix;
    assign vline_cur = vs_start ? 12'd0 : vline;
    assign xcnt_cur  = vs_start ? 12'd0 : xcnt;
    assign ycnt_cur  = vs_start ? 12'd0 : ycnt;
    assign col_cur   = vs_start ? 12'd0 : col;
    assign row_cur   = vs_start ? 12'd0 : row;

    assign in_win = active && de0
                    && (hpix_cur >= X_LO) && (hpix_cur < X_HI)
                    && (vline_cur >= Y_LO) && (vline_cur < Y_HI);
    assign fire   = in_win && (xcnt_cur == 12'd0) && (ycnt_cur == 12'd0);

    always_comb begin : counters_next
        hpix_d     = hpix;
        vline_d    = vline;
        xcnt_d     = xcnt;
        ycnt_d     = ycnt;
        col_d      = col;
        row_d      = row;
        line_err_d = line_err;
        if (active) begin
            hpix_d     = hpix_cur;
            vline_d    = vline_cur;
            xcnt_d     = xcnt_cur;
            ycnt_d     = ycnt_cur;
            col_d      = col_cur;
            row_d      = row_cur;
            line_err_d = vs_start ? 1'b0 : line_err;
            if (de0 && hpix_cur != SAT)
                hpix_d = hpix_cur + 12'd1;
            if (in_win) begin
                if (xcnt_cur == XC_LAST) begin
                    xcnt_d = 12'd0;
                    col_d  = (col_cur == COL_LAST) ? 12'd0 : col_cur + 12'd1;
                end else begin
                    xcnt_d = xcnt_cur + 12'd1;
                end
            end
            if (line_end) begin
                if (hpix != H_REQ)
                    line_err_d = 1'b1;
                if (vline != SAT)
                    vline_d = vline + 12'd1;
                hpix_d = 12'd0;
                xcnt_d = 12'd0;
                col_d  = 12'd0;
                if (vline >= Y_LO && vline < Y_HI) begin
                    if (ycnt == YC_LAST) begin
                        ycnt_d = 12'd0;
                        row_d  = (row == ROW_LAST) ? 12'd0 : row + 12'd1;
                    end else begin
                        ycnt_d = ycnt + 12'd1;
                    end
                end
            end
            // HS in blanking re-aligns the horizontal sub-counters even if a DE fall was missed.
            if (hs_start && !de0) begin
                xcnt_d = 12'd0;
                col_d  = 12'd0;
            end
        end
    end

    always_comb begin : lock_next
        frame_ok_d = (vline == V_REQ) && !line_err;
        if (!frame_ok_d)
            good_d = '0;
        else if (good_cnt == G_MAX)
            good_d = good_cnt;
        else
            good_d = good_cnt + G_ONE;
        locked_d   = (good_d == G_MAX);
        locked_nxt = frame_end ? locked_d : locked;
`ifdef CAPTURE_LOCK_GATE_EN
        we_d = fire && locked_nxt;
`else
        we_d = fire;
`endif
    end

    always_ff @(posedge clock25mhz) begin
        if (!resetn) begin
            d0         <= '0;
            de0        <= 1'b0;
            hs0        <= ~SYNC_ACT;
            vs0        <= ~SYNC_ACT;
            de1        <= 1'b0;
            hs1        <= ~SYNC_ACT;
            vs1        <= ~SYNC_ACT;
            state_q    <= IDLE;
            hpix       <= '0;
            vline      <= '0;
            xcnt       <= '0;
            ycnt       <= '0;
            col        <= '0;
            row        <= '0;
            line_err   <= 1'b0;
            good_cnt   <= '0;
            we         <= 1'b0;
            x          <= '0;
            y          <= '0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            d0         <= HDMI_RX_D;
            de0        <= HDMI_RX_DE;
            hs0        <= HDMI_RX_HS;
            vs0        <= HDMI_RX_VS;
            de1        <= de0;
            hs1        <= hs0;
            vs1        <= vs0;
            state_q    <= state_d;
            hpix       <= hpix_d;
            vline      <= vline_d;
            xcnt       <= xcnt_d;
            ycnt       <= ycnt_d;
            col        <= col_d;
            row        <= row_d;
            line_err   <= line_err_d;
            frame_done <= frame_end;
            we         <= we_d;
            if (frame_end) begin
                frame_ok <= frame_ok_d;
                good_cnt <= good_d;
                locked   <= locked_d;
            end
            if (we_d) begin
                x <= col_cur;
                y <= row_cur;
                r <= d0[23:16];
                g <= d0[15:8];
                b <= d0[7:0];
            end
        end
    end

endmodule

// File: tb/tb_hdmi_capture.sv
// Scoreboard bench for hdmi_capture on a reduced geometry (24x16 active, 6x4 output, 3x3 blocks).
// Expected writes and frame results come from a frame-level model; a negedge monitor pops and compares.
module tb_hdmi_capture;
    localparam int WIDTH = 6, HEIGHT = 4, XDIV = 3, YDIV = 3, XSTART = 3, YSTART = 2;
    localparam int HSIZE = 24, VSIZE = 16, SYNC_POL = 0, LOCK_FRAMES = 2;
    localparam int LT = HSIZE + 8;
    localparam logic SACT = (SYNC_POL != 0);
`ifdef CAPTURE_LOCK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clock25mhz = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] HDMI_RX_D = '0;
    logic        HDMI_RX_DE = 1'b0;
    logic        HDMI_RX_HS = ~SACT;
    logic        HDMI_RX_VS = ~SACT;
    logic        we, frame_done, frame_ok, locked;
    logic [11:0] x, y;
    logic [7:0]  r, g, b;

    hdmi_capture #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XDIV(XDIV), .YDIV(YDIV), .XSTART(XSTART), .YSTART(YSTART),
        .HSIZE(HSIZE), .VSIZE(VSIZE), .SYNC_POL(SYNC_POL), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clock25mhz(clock25mhz), .resetn(resetn), .HDMI_RX_D(HDMI_RX_D), .HDMI_RX_DE(HDMI_RX_DE),
        .HDMI_RX_HS(HDMI_RX_HS), .HDMI_RX_VS(HDMI_RX_VS), .we(we), .x(x), .y(y), .r(r), .g(g), .b(b),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked)
    );

    always #20 clock25mhz = ~clock25mhz;

    typedef struct { logic [11:0] x; logic [11:0] y; logic [23:0] rgb; } wr_t;
    typedef struct { bit ok; bit lk; int nwr; } fd_t;
    wr_t exp_wr[$];
    fd_t exp_fd[$];
    wr_t ew;
    fd_t ef;

    int n_cmp = 0, n_err = 0;
    int wr_in_frame = 0;
    logic [23:0] pix [VSIZE][HSIZE];

    // frame-level reference model state
    bit m_in_frame = 0, m_prev_ok = 0, m_lk = 0;
    int m_good = 0, m_prev_nwr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock25mhz) begin
        if (!resetn) begin
            wr_in_frame = 0;
        end else begin
            if (we) begin
                wr_in_frame++;
                chk("x_range", longint'(x < 12'(WIDTH)), 1);
                chk("y_range", longint'(y < 12'(HEIGHT)), 1);
                if (exp_wr.size() == 0) begin
                    chk("we_unexpected", longint'(we), 0);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("wr_x", longint'(x), longint'(ew.x));
                    chk("wr_y", longint'(y), longint'(ew.y));
                    chk("wr_rgb", longint'({r, g, b}), longint'(ew.rgb));
                end
            end
            if (frame_done) begin
                if (exp_fd.size() == 0) begin
                    chk("frame_done_unexpected", longint'(frame_done), 0);
                end else begin
                    ef = exp_fd.pop_front();
                    chk("frame_ok", longint'(frame_ok), longint'(ef.ok));
                    chk("locked", longint'(locked), longint'(ef.lk));
                    chk("writes_per_frame", longint'(wr_in_frame), longint'(ef.nwr));
                end
                wr_in_frame = 0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"}, longint'(we), 0);
        chk({tag, "_xy"}, longint'({x, y}), 0);
        chk({tag, "_rgb"}, longint'({r, g, b}), 0);
        chk({tag, "_frame_done"}, longint'(frame_done), 0);
        chk({tag, "_frame_ok"}, longint'(frame_ok), 0);
        chk({tag, "_locked"}, longint'(locked), 0);
    endtask

    task automatic drive_line(input bit vs_act, input int v, input int len, input int rst_at);
        for (int c = 0; c < LT; c++) begin
            @(posedge clock25mhz); #1;
            HDMI_RX_DE = (c < len);
            HDMI_RX_D  = (c < len) ? pix[v][c] : 24'($urandom);
            HDMI_RX_HS = (c >= HSIZE + 2 && c < HSIZE + 5) ? SACT : ~SACT;
            HDMI_RX_VS = vs_act ? SACT : ~SACT;
            if (c == rst_at) resetn = 1'b0;
            if (rst_at >= 0 && c == rst_at + 2) check_outputs_zero("mid_reset");
            if (c == rst_at + 3) resetn = 1'b1;
        end
    endtask

    // One frame: VS (2 lines), back porch (2), nlines active, front porch (1).
    task automatic drive_frame(input int nlines, input int short_idx, input bit rnd, input int rst_line);
        int nexp;
        int len;
        for (int v = 0; v < VSIZE; v++)
            for (int h = 0; h < HSIZE; h++)
                pix[v][h] = rnd ? 24'($urandom) : {8'(h), 8'(v), 8'h5A};
        if (m_in_frame) begin
            m_good = m_prev_ok ? ((m_good + 1 > LOCK_FRAMES) ? LOCK_FRAMES : m_good + 1) : 0;
            m_lk   = (m_good == LOCK_FRAMES);
            exp_fd.push_back('{m_prev_ok, m_lk, m_prev_nwr});
        end
        m_in_frame = 1;
        nexp = 0;
        if (rst_line < 0 && (!GATE || m_lk)) begin
            for (int j = 0; j < HEIGHT; j++)
                for (int i = 0; i < WIDTH; i++) begin
                    int vy = YSTART + YDIV * j;
                    int hx = XSTART + XDIV * i;
                    int ll = (vy == short_idx) ? HSIZE - 1 : HSIZE;
                    if (vy < nlines && hx < ll) begin
                        exp_wr.push_back('{12'(i), 12'(j), pix[vy][hx]});
                        nexp++;
                    end
                end
        end
        m_prev_nwr = nexp;
        m_prev_ok  = (nlines == VSIZE) && (short_idx < 0);
        repeat (2) drive_line(1'b1, 0, 0, -1);
        repeat (2) drive_line(1'b0, 0, 0, -1);
        for (int v = 0; v < nlines; v++) begin
            len = (v == short_idx) ? HSIZE - 1 : HSIZE;
            drive_line(1'b0, v, len, (v == rst_line) ? 2 : -1);
        end
        drive_line(1'b0, 0, 0, -1);
        if (rst_line >= 0) begin
            m_in_frame = 0;
            m_good     = 0;
            m_lk       = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (4) @(posedge clock25mhz);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;
        // DE activity before the first VS must be ignored
        for (int c = 0; c < 40; c++) begin
            @(posedge clock25mhz); #1;
            HDMI_RX_DE = 1'($urandom);
            HDMI_RX_D  = 24'($urandom);
        end
        HDMI_RX_DE = 1'b0;
        drive_frame(VSIZE,     -1, 1'b0, -1);
        drive_frame(VSIZE,     -1, 1'b0, -1);
        drive_frame(VSIZE,     -1, 1'b0, -1);
        drive_frame(VSIZE,      5, 1'b0, -1);
        drive_frame(VSIZE,     -1, 1'b1, -1);
        drive_frame(VSIZE,     -1, 1'b1, -1);
        drive_frame(VSIZE - 1, -1, 1'b1, -1);
        drive_frame(VSIZE,     -1, 1'b1, -1);
        drive_frame(VSIZE,     -1, 1'b1,  0);
        drive_frame(VSIZE,     -1, 1'b1, -1);
        drive_frame(VSIZE,     -1, 1'b1, -1);
        drive_frame(0,         -1, 1'b0, -1);
        repeat (20) @(posedge clock25mhz);
        #1;
        chk("wr_queue_left", longint'(exp_wr.size()), 0);
        chk("fd_queue_left", longint'(exp_fd.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hdmi_capture.md
Name: hdmi_capture

Overview:
- Receive-side counterpart of the HDMI 640x480@60 timing generator.
- Accepts a parallel RGB stream with DE/HS/VS and checks the frame geometry.
- Decimates the centred 480x432 window by 3x3 into a 160x144 framebuffer write stream.
- Sits between an HDMI receiver chip and the framebuffer write port. Used for loopback self-test and for video capture.

Parameters:
- WIDTH, 160, output frame width in pixels
- HEIGHT, 144, output frame height in lines
- XDIV, 3, horizontal decimation factor
- YDIV, 3, vertical decimation factor
- XSTART, 80, first captured pixel, counted from start of the DE-active line
- YSTART, 24, first captured line, counted from the first DE-active line of the frame
- HSIZE, 640, required DE-active pixels per line
- VSIZE, 480, required DE-active lines per frame
- SYNC_POL, 0, active level of HS/VS (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- clock25mhz  in  1  pixel clock
- resetn  in  1  synchronous active-low reset
- HDMI_RX_D  in  24  pixel data, {r,g,b}
- HDMI_RX_DE  in  1  data enable
- HDMI_RX_HS  in  1  horizontal sync
- HDMI_RX_VS  in  1  vertical sync
- we  out  1  framebuffer write strobe
- x  out  12  write column, 0..WIDTH-1
- y  out  12  write row, 0..HEIGHT-1
- r  out  8  write red
- g  out  8  write green
- b  out  8  write blue
- frame_done  out  1  one-cycle pulse at the end of each captured frame
- frame_ok  out  1  geometry result of the last completed frame
- locked  out  1  LOCK_FRAMES consecutive good frames seen

Behaviour:
- Clocking and reset: one clock, clock25mhz. Reset is synchronous, active-low, on resetn.
- Reset values: we, x, y, r, g, b, frame_done, frame_ok and locked are all 0. State is IDLE and all counters are 0.
- Input stage: all RX pins are registered once (stage 0). Edge detection compares stage 0 with a stage 1 copy.
- vs_start: the stage-0 VS goes from inactive to active level. hs_start is defined the same way (informational only).
- IDLE state:
  - Ignore DE and data.
  - On vs_start, go to FRAME and clear the per-frame counters.
  - No frame_done on this edge.
- FRAME state:
  - hpix counts DE-high cycles within the current line.
  - A DE falling edge ends a line: vline increments and hpix clears.
  - If hpix != HSIZE at a DE falling edge, set a sticky line_err.
  - hpix saturates at 4095.
  - vline saturates at 4095.
- Frame end: vs_start while in FRAME.
  - frame_ok = (vline == VSIZE) && !line_err.
  - frame_done pulses one cycle, together with the frame_ok update.
  - Counters and line_err clear. State stays FRAME.
- Lock:
  - good_cnt increments on each ok frame and saturates at LOCK_FRAMES.
  - A bad frame clears good_cnt and drops locked in the same cycle as frame_done.
  - locked = (good_cnt == LOCK_FRAMES), registered, updated with frame_done.
- Capture window: stage-0 sample with DE=1, XSTART <= hpix < XSTART+XDIV*WIDTH, and YSTART <= vline < YSTART+YDIV*HEIGHT.
- Decimation:
  - Sub-counters xcnt (0..XDIV-1) and ycnt (0..YDIV-1).
  - The write fires only on the first pixel of each block (xcnt==0, ycnt==0). That pixel equals the transmitter's replicated value.
  - x advances once per XDIV window pixels. x wraps to 0 at line end.
  - y advances once per YDIV window lines. y wraps to 0 at frame end.
- Write timing: we, x, y, r, g, b are registered. A pixel present at the pins on cycle N produces we on cycle N+2.
  - we is high for exactly one cycle per output pixel.
  - r, g, b hold the last written value while we is low.
- Writes per frame: exactly WIDTH*HEIGHT (23040) for well-formed input.
- Malformed input: writes still follow the window rules, and x/y never exceed WIDTH-1/HEIGHT-1.
- Simultaneous vs_start and DE high: frame end takes priority, and that sample counts as hpix 0 of the new frame.
- Reset mid-frame: everything returns to reset values and IDLE. No writes occur until after the next vs_start.

Optional Feature:
- Macro: CAPTURE_LOCK_GATE_EN.
- Defined: we is forced to 0 whenever locked=0. Writes start with the first frame after lock is achieved, and stop on the cycle locked drops.
- Undefined: writes occur in every FRAME-state frame regardless of locked.

Test Plan:
- Reset, then 3 well-formed frames driven with the transmitter timing and pixel = {h[7:0], v[7:0], 8'h5A}:
  - Each frame gives 23040 writes.
  - Write (x,y) carries the source pixel (80+3x, 24+3y).
  - frame_ok=1 at every frame_done. locked rises at the 2nd frame_done.
- Frame 4 has one line of 639 DE pixels -> frame_done with frame_ok=0, locked falls the same cycle. Frames 5 and 6 good -> locked rises at the end of frame 6.
- Frame with 479 active lines -> frame_ok=0 and locked=0. x/y stay in range and the write count is 23040.
- resetn low for 3 cycles mid-frame -> all outputs 0. DE activity before the next VS produces no we and no frame_done.
- With CAPTURE_LOCK_GATE_EN: 0 writes in frames 1-2, 23040 in frame 3. Without the macro: 23040 writes in frame 1.
- DE toggling in IDLE, before the first VS -> no we and no frame_done.
